// File: rtl/controller_interface_pkg.sv
// Shared types and constants for the NES-style controller reader.
package controller_interface_pkg;

  // Read-sequence states: latch the controllers, then alternate sample/shift
  // eight times, then publish the captured bytes.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    SAMPLE = 3'd2,
    SHIFT  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int BUTTONS_PER_CONTROLLER = 8;
  localparam int BIT_CNT_W              = 3;

  // Bit position of each button in a captured byte (MSB arrives first).
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/controller_interface_shreg.sv
// Per-controller capture register: shifts one active-high button bit into the
// LSB on each enabled cycle, so after eight shifts the first bit sits in bit 7.
module controller_shreg
  import controller_interface_pkg::*;
(
  input  logic                              clk_1,
  input  logic                              rst,
  input  logic                              shift_en,
  input  logic                              data_bit,
  output logic [BUTTONS_PER_CONTROLLER-1:0] shreg_out
);

  logic [BUTTONS_PER_CONTROLLER-1:0] shreg_q;
  logic [BUTTONS_PER_CONTROLLER-1:0] shreg_d;

  // Next value: shift in the new bit when enabled, otherwise hold.
  always_comb begin
    shreg_d = shreg_q;
    if (shift_en) begin
      shreg_d = {shreg_q[BUTTONS_PER_CONTROLLER-2:0], data_bit};
    end
  end

  // Capture register with synchronous clear.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign shreg_out = shreg_q;

endmodule

// File: rtl/controller_interface.sv
// Serial reader for NUM_CONTROLLERS NES-style pads sharing one latch and one
// shift clock. A shared FSM and bit counter drive all pads in parallel; each
// pad's bits land in its own controller_shreg, and the full result is copied
// to buttons_out in a single cycle so the CPU never sees a partial read.
module controller_interface
  import controller_interface_pkg::*;
#(
  parameter int NUM_CONTROLLERS = 2
) (
  input  logic                                              clk_1,
  input  logic                                              rst,
  input  logic                                              start,
  output logic                                              controller_clk,
  output logic                                              controller_latch,
  input  logic [NUM_CONTROLLERS-1:0]                        data_B,
  output logic [BUTTONS_PER_CONTROLLER*NUM_CONTROLLERS-1:0] buttons_out
);

  localparam int BUS_W = BUTTONS_PER_CONTROLLER * NUM_CONTROLLERS;

  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic                   latch_q, latch_d;
  logic                   sclk_q, sclk_d;
  logic [BUS_W-1:0]       buttons_q, buttons_d;
  logic [BUS_W-1:0]       shreg_bus;
  logic                   shift_en;

  // Bits are sampled while the shift clock is low, just before it rises.
  assign shift_en = (state_q == SAMPLE);

  for (genvar gi = 0; gi < NUM_CONTROLLERS; gi++) begin : g_ctrl
    controller_shreg u_shreg (
      .clk_1     (clk_1),
      .rst       (rst),
      .shift_en  (shift_en),
      .data_bit  (~data_B[gi]),
      .shreg_out (shreg_bus[gi*BUTTONS_PER_CONTROLLER +: BUTTONS_PER_CONTROLLER])
    );
  end

  // Next-state, bit counter and output decode; outputs are registered from
  // the next state so the pad-side strobes are glitch-free.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    buttons_d = buttons_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        bit_d   = BIT_CNT_W'(BUTTONS_PER_CONTROLLER - 1);
        state_d = SAMPLE;
      end
      SAMPLE: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        if (bit_q == '0) begin
          state_d = DONE;
        end else begin
          bit_d   = bit_q - 1'b1;
          state_d = SAMPLE;
        end
      end
      DONE: begin
        buttons_d = shreg_bus;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    latch_d = (state_d == LATCH);
    sclk_d  = (state_d == SHIFT);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      latch_q   <= 1'b0;
      sclk_q    <= 1'b0;
      buttons_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      latch_q   <= latch_d;
      sclk_q    <= sclk_d;
      buttons_q <= buttons_d;
    end
  end

  assign controller_latch = latch_q;
  assign controller_clk   = sclk_q;
  assign buttons_out      = buttons_q;

endmodule

// File: tb/tb_controller_interface.sv
// Bench for controller_interface with two behavioural 4021-style pads.
module tb_controller_interface;

  logic        clk_1 = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        ctrl_clk;
  logic        ctrl_latch;
  logic [1:0]  data_B;
  logic [15:0] buttons_out;

  logic [7:0]  pressed [2];
  logic [7:0]  sr [2];
  logic        disc = 1'b0;

  int tests  = 0;
  int failed = 0;

  controller_interface #(.NUM_CONTROLLERS(2)) dut (
    .clk_1            (clk_1),
    .rst              (rst),
    .start            (start),
    .controller_clk   (ctrl_clk),
    .controller_latch (ctrl_latch),
    .data_B           (data_B),
    .buttons_out      (buttons_out)
  );

  always #5 clk_1 = ~clk_1;

  // Pad model: parallel load while latched, shift toward bit 7 on rising clock.
  always @(posedge ctrl_clk or posedge ctrl_latch) begin
    for (int i = 0; i < 2; i++) begin
      if (ctrl_latch) sr[i] <= ~pressed[i];
      else            sr[i] <= {sr[i][6:0], 1'b1};
    end
  end
  assign data_B = disc ? 2'b11 : {sr[1][7], sr[0][7]};

  // Strobe monitor, sampled on the falling edge.
  int   cyc = 0, lat_cnt = 0, pulse_cnt = 0;
  int   last_rise = 0, prev_rise = 0;
  logic clk_prev = 1'b0, lat_prev = 1'b0;
  always @(negedge clk_1) begin
    cyc = cyc + 1;
    if (ctrl_latch) lat_cnt = lat_cnt + 1;
    if (ctrl_latch && !lat_prev) begin
      prev_rise = last_rise;
      last_rise = cyc;
    end
    if (ctrl_clk && !clk_prev) pulse_cnt = pulse_cnt + 1;
    clk_prev = ctrl_clk;
    lat_prev = ctrl_latch;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", nm, act);
    end
  endtask

  // One full sequence with start held for 'hold' cycles; returns at the
  // falling edge after the result is published, plus one idle cycle.
  task automatic run_seq(input int hold, output int lats, output int pulses);
    int l0, p0;
    l0 = lat_cnt;
    p0 = pulse_cnt;
    start = 1'b1;
    repeat (hold) @(negedge clk_1);
    start = 1'b0;
    repeat (20 - hold) @(negedge clk_1);
    lats   = lat_cnt - l0;
    pulses = pulse_cnt - p0;
  endtask

  typedef struct {
    logic [7:0]  p0;
    logic [7:0]  p1;
    logic        disc;
    int          hold;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lats, pulses, l0, p0;

    vecs[0] = '{8'hFE, 8'h7F, 1'b0, 1, 16'h7FFE};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, 1, 16'h0000};
    vecs[2] = '{8'h80, 8'h00, 1'b0, 1, 16'h0080};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 1, 16'h0000};
    vecs[4] = '{8'hA5, 8'h3C, 1'b0, 3, 16'h3CA5};
    vecs[5] = '{8'hFF, 8'hFF, 1'b0, 1, 16'hFFFF};
    vecs[6] = '{8'h80, 8'h01, 1'b0, 1, 16'h0180};

    pressed[0] = 8'hFE;
    pressed[1] = 8'h7F;
    repeat (3) @(negedge clk_1);
    chk("reset_buttons", 32'(buttons_out), 32'h0);
    chk("reset_latch", 32'(ctrl_latch), 32'h0);
    chk("reset_clk", 32'(ctrl_clk), 32'h0);
    rst = 1'b0;
    @(negedge clk_1);

    // Exact latency: old value after 18 edges, new value after 19th.
    l0 = lat_cnt;
    p0 = pulse_cnt;
    start = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk_1);
      if (n == 9) start = 1'b0;
    end
    chk("latency_before", 32'(buttons_out), 32'h0);
    @(negedge clk_1);
    chk("latency_after", 32'(buttons_out), 32'h7FFE);
    @(negedge clk_1);
    chk("s1_latch_cycles", 32'(lat_cnt - l0), 32'd1);
    chk("s1_clk_pulses", 32'(pulse_cnt - p0), 32'd8);

    // Table-driven patterns.
    for (int v = 0; v < 7; v++) begin
      pressed[0] = vecs[v].p0;
      pressed[1] = vecs[v].p1;
      disc       = vecs[v].disc;
      run_seq(vecs[v].hold, lats, pulses);
      chk($sformatf("vec%0d_buttons", v), 32'(buttons_out), 32'(vecs[v].exp));
      chk($sformatf("vec%0d_latch", v), 32'(lats), 32'd1);
      chk($sformatf("vec%0d_pulses", v), 32'(pulses), 32'd8);
    end
    disc = 1'b0;

    // Buttons change after latch: result must be the snapshot.
    pressed[0] = 8'hFE;
    pressed[1] = 8'h7F;
    start = 1'b1;
    @(negedge clk_1);
    start = 1'b0;
    repeat (3) @(negedge clk_1);
    pressed[0] = 8'h00;
    pressed[1] = 8'h00;
    repeat (16) @(negedge clk_1);
    chk("snapshot", 32'(buttons_out), 32'h7FFE);

    // Mid-sequence start pulse is ignored.
    pressed[0] = 8'h12;
    pressed[1] = 8'h34;
    l0 = lat_cnt;
    p0 = pulse_cnt;
    start = 1'b1;
    @(negedge clk_1);
    start = 1'b0;
    repeat (5) @(negedge clk_1);
    start = 1'b1;
    @(negedge clk_1);
    start = 1'b0;
    repeat (13) @(negedge clk_1);
    chk("midstart_latch", 32'(lat_cnt - l0), 32'd1);
    chk("midstart_pulses", 32'(pulse_cnt - p0), 32'd8);
    chk("midstart_buttons", 32'(buttons_out), 32'h3412);

    // Continuous polling: one IDLE cycle between sequences.
    start = 1'b1;
    repeat (60) @(negedge clk_1);
    start = 1'b0;
    chk("poll_period", 32'(last_rise - prev_rise), 32'd19);
    repeat (25) @(negedge clk_1);

    // Reset mid-sequence.
    pressed[0] = 8'h55;
    pressed[1] = 8'hAA;
    start = 1'b1;
    @(negedge clk_1);
    start = 1'b0;
    repeat (6) @(negedge clk_1);
    rst = 1'b1;
    @(negedge clk_1);
    chk("rst_mid_latch", 32'(ctrl_latch), 32'h0);
    chk("rst_mid_clk", 32'(ctrl_clk), 32'h0);
    chk("rst_mid_buttons", 32'(buttons_out), 32'h0);
    rst = 1'b0;
    l0 = lat_cnt;
    p0 = pulse_cnt;
    repeat (5) @(negedge clk_1);
    chk("rst_idle_latch", 32'(lat_cnt - l0), 32'd0);
    chk("rst_idle_pulses", 32'(pulse_cnt - p0), 32'd0);
    run_seq(1, lats, pulses);
    chk("rst_fresh_buttons", 32'(buttons_out), 32'hAA55);
    chk("rst_fresh_pulses", 32'(pulses), 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
